// File: rtl/count_ctrl_if.sv
// Button/auto-repeat controller bus: control inputs, counter value and step outputs.
interface count_ctrl_if;
    logic        btn_level;
    logic        tick;
    logic        uphdnl_sw;
    logic        auto_sw;
    logic        sat_sw;
    logic [15:0] q;
    logic        inc;
    logic        uphdnl;
    logic        at_limit;
    logic [1:0]  state;

    modport master (
        output btn_level, tick, uphdnl_sw, auto_sw, sat_sw, q,
        input  inc, uphdnl, at_limit, state
    );

    modport slave (
        input  btn_level, tick, uphdnl_sw, auto_sw, sat_sw, q,
        output inc, uphdnl, at_limit, state
    );
endinterface

// File: rtl/count_ctrl.sv
// Up/down counter step controller: single press, hold-to-repeat and free-run
// modes, with optional saturation at MIN_VAL/MAX_VAL.
module count_ctrl #(
    parameter int unsigned HOLD_TICKS = 500,
    parameter int unsigned REPEAT_DIV = 50,
    parameter logic [15:0] MAX_VAL    = 16'hFFFF,
    parameter logic [15:0] MIN_VAL    = 16'h0000
) (
    input logic         clk,
    input logic         reset,
    count_ctrl_if.slave bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_PRESS  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;
    localparam logic [1:0] ST_AUTO   = 2'd3;

    localparam logic [15:0] HOLD_LAST = 16'(HOLD_TICKS - 1);
    localparam logic [15:0] RPT_LAST  = 16'(REPEAT_DIV - 1);

    logic [1:0]  state_q, state_d;
    logic [15:0] hold_cnt_q, hold_cnt_d;
    logic [15:0] rpt_cnt_q, rpt_cnt_d;
    logic        btn_prev_q;
    // Set once the button has been seen released; a button held through
    // reset therefore cannot produce a press until released and pressed again.
    logic        armed_q, armed_d;
    logic        inc_q, inc_d;
    logic        uphdnl_q, uphdnl_d;
    logic        at_limit_q, at_limit_d;

    logic press;
    logic req;
    logic at_lim_now;

    assign press = bus.btn_level & ~btn_prev_q & armed_q;

    assign at_lim_now = bus.sat_sw &
                        (( bus.uphdnl_sw & (bus.q == MAX_VAL)) |
                         (~bus.uphdnl_sw & (bus.q == MIN_VAL)));

    // Next-state, counter and step-request decode.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        rpt_cnt_d  = rpt_cnt_q;
        req        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (press) begin
                    req        = 1'b1;
                    state_d    = ST_PRESS;
                    hold_cnt_d = '0;
                    rpt_cnt_d  = '0;
                end
            end
            ST_PRESS: begin
                if (!bus.btn_level) begin
                    state_d = ST_IDLE;
                end else if (bus.tick) begin
                    hold_cnt_d = (hold_cnt_q == 16'hFFFF) ? hold_cnt_q : hold_cnt_q + 16'd1;
                    if (hold_cnt_q == HOLD_LAST) begin
                        req       = 1'b1;
                        rpt_cnt_d = '0;
                        state_d   = ST_REPEAT;
                    end
                end
            end
            ST_REPEAT: begin
                if (!bus.btn_level) begin
                    state_d = ST_IDLE;
                end else if (bus.tick) begin
                    if (rpt_cnt_q == RPT_LAST) begin
                        req       = 1'b1;
                        rpt_cnt_d = '0;
                    end else begin
                        rpt_cnt_d = (rpt_cnt_q == 16'hFFFF) ? rpt_cnt_q : rpt_cnt_q + 16'd1;
                    end
                end
            end
            default: begin
                // AUTO: every tick steps; leaving AUTO always lands in IDLE
                req     = bus.tick;
                state_d = ST_IDLE;
            end
        endcase
        // Free-run switch overrides any button activity in the other states
        if (bus.auto_sw) begin
            state_d = ST_AUTO;
            if (state_q != ST_AUTO) begin
                req        = 1'b0;
                hold_cnt_d = hold_cnt_q;
                rpt_cnt_d  = rpt_cnt_q;
            end
        end
    end

    // Output strobe: suppressed at a saturation limit, and never two in a row.
    always_comb begin
        armed_d    = armed_q | ~bus.btn_level;
        inc_d      = req & ~at_lim_now & ~inc_q;
        uphdnl_d   = inc_d ? bus.uphdnl_sw : uphdnl_q;
        at_limit_d = at_lim_now;
    end

    // FSM state, hold/repeat counters and button edge history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            rpt_cnt_q  <= '0;
            btn_prev_q <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            rpt_cnt_q  <= rpt_cnt_d;
            btn_prev_q <= bus.btn_level;
            armed_q    <= armed_d;
        end
    end

    // Registered outputs to the counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inc_q      <= 1'b0;
            uphdnl_q   <= 1'b1;
            at_limit_q <= 1'b0;
        end else begin
            inc_q      <= inc_d;
            uphdnl_q   <= uphdnl_d;
            at_limit_q <= at_limit_d;
        end
    end

    assign bus.inc      = inc_q;
    assign bus.uphdnl   = uphdnl_q;
    assign bus.at_limit = at_limit_q;
    assign bus.state    = state_q;

endmodule

// File: tb/tb_count_ctrl.sv
// Bench for count_ctrl: scoreboard of expected inc pulses (cycle, direction),
// a saturation vector table, and hand-written press/repeat/auto/reset sequences.
module tb_count_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    count_ctrl_if ifc ();

    count_ctrl #(.HOLD_TICKS(4), .REPEAT_DIV(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    typedef struct {
        int   cyc;
        logic dir;
    } exp_t;

    typedef struct {
        logic        sat;
        logic        dir;
        logic [15:0] q;
        logic        lim;
    } vec_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_inc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Every observed inc pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (ifc.inc === 1'b1) begin
            n_inc++;
            if (sb.size() == 0) begin
                chk("inc_spurious", int'(ifc.inc), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("inc_cycle", cyc, e.cyc);
                chk("inc_dir", int'(ifc.uphdnl), int'(e.dir));
            end
        end
    end

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_inc(input int at_cyc, input logic dir);
        exp_t e;
        e.cyc = at_cyc;
        e.dir = dir;
        sb.push_back(e);
    endtask

    // One tick strobe followed by three quiet cycles.
    task automatic pulse_tick(input bit step, input logic dir);
        ifc.tick = 1'b1;
        if (step) expect_inc(cyc + 1, dir);
        clk1();
        ifc.tick = 1'b0;
        repeat (3) clk1();
    endtask

    task automatic sb_drain(input string nm);
        repeat (3) clk1();
        chk(nm, sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        vec_t vt[8];
        int   n0;
        logic last_dir;

        vt[0] = '{1'b1, 1'b0, 16'h0000, 1'b1};
        vt[1] = '{1'b1, 1'b1, 16'h0000, 1'b0};
        vt[2] = '{1'b1, 1'b1, 16'hFFFF, 1'b1};
        vt[3] = '{1'b1, 1'b0, 16'hFFFF, 1'b0};
        vt[4] = '{1'b0, 1'b0, 16'h0000, 1'b0};
        vt[5] = '{1'b0, 1'b1, 16'hFFFF, 1'b0};
        vt[6] = '{1'b1, 1'b0, 16'h0001, 1'b0};
        vt[7] = '{1'b1, 1'b1, 16'hFFFE, 1'b0};

        ifc.btn_level = 1'b1;
        ifc.tick      = 1'b0;
        ifc.uphdnl_sw = 1'b1;
        ifc.auto_sw   = 1'b0;
        ifc.sat_sw    = 1'b0;
        ifc.q         = 16'h1234;
        reset         = 1'b0;

        // Reset with the button already held
        #1 reset = 1'b1;
        #1;
        chk("rst_state", int'(ifc.state), 0);
        chk("rst_inc", int'(ifc.inc), 0);
        chk("rst_uphdnl", int'(ifc.uphdnl), 1);
        chk("rst_at_limit", int'(ifc.at_limit), 0);
        repeat (3) clk1();
        reset = 1'b0;
        repeat (5) begin
            clk1();
            chk("held_after_rst_state", int'(ifc.state), 0);
        end
        ifc.btn_level = 1'b0;
        repeat (2) clk1();
        chk("held_after_rst_no_inc", n_inc, 0);

        // Single short press
        n0 = n_inc;
        ifc.uphdnl_sw = 1'b1;
        ifc.btn_level = 1'b1;
        expect_inc(cyc + 1, 1'b1);
        clk1();
        chk("press_state", int'(ifc.state), 1);
        pulse_tick(1'b0, 1'b1);
        pulse_tick(1'b0, 1'b1);
        ifc.btn_level = 1'b0;
        clk1();
        chk("release_state", int'(ifc.state), 0);
        sb_drain("single_press_drain");
        chk("single_press_count", n_inc - n0, 1);

        // Hold through auto-repeat
        n0 = n_inc;
        ifc.uphdnl_sw = 1'b0;
        ifc.btn_level = 1'b1;
        expect_inc(cyc + 1, 1'b0);
        clk1();
        clk1();
        for (int t = 1; t <= 10; t++) begin
            pulse_tick(t == 4 || (t > 4 && (t - 4) % 2 == 0), 1'b0);
            if (t == 4) chk("repeat_state", int'(ifc.state), 2);
        end
        ifc.btn_level = 1'b0;
        clk1();
        chk("repeat_release_state", int'(ifc.state), 0);
        sb_drain("repeat_drain");
        chk("repeat_count", n_inc - n0, 5);

        // Free-run with interleaved presses, then back-to-back ticks
        n0 = n_inc;
        ifc.uphdnl_sw = 1'b1;
        ifc.auto_sw   = 1'b1;
        clk1();
        chk("auto_state", int'(ifc.state), 3);
        for (int t = 0; t < 10; t++) begin
            ifc.tick = 1'b1;
            expect_inc(cyc + 1, 1'b1);
            clk1();
            ifc.tick      = 1'b0;
            ifc.btn_level = 1'b1;
            clk1();
            ifc.btn_level = 1'b0;
            clk1();
            clk1();
        end
        chk("auto_state_held", int'(ifc.state), 3);
        ifc.tick = 1'b1;
        expect_inc(cyc + 1, 1'b1);
        expect_inc(cyc + 3, 1'b1);
        repeat (4) clk1();
        ifc.tick = 1'b0;
        sb_drain("auto_drain");
        chk("auto_count", n_inc - n0, 12);

        // Saturation table in free-run mode
        last_dir = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ifc.sat_sw    = vt[i].sat;
            ifc.uphdnl_sw = vt[i].dir;
            ifc.q         = vt[i].q;
            clk1();
            chk($sformatf("at_limit_row%0d", i), int'(ifc.at_limit), int'(vt[i].lim));
            pulse_tick(!vt[i].lim, vt[i].dir);
            if (!vt[i].lim) last_dir = vt[i].dir;
            chk($sformatf("uphdnl_row%0d", i), int'(ifc.uphdnl), int'(last_dir));
        end
        sb_drain("table_drain");

        // Leave free-run with a press in the same cycle: press is not captured
        ifc.sat_sw    = 1'b0;
        ifc.q         = 16'h1234;
        ifc.auto_sw   = 1'b0;
        ifc.btn_level = 1'b1;
        clk1();
        chk("auto_exit_state", int'(ifc.state), 0);
        repeat (3) clk1();
        chk("auto_exit_no_press", int'(ifc.state), 0);
        ifc.btn_level = 1'b0;
        sb_drain("auto_exit_drain");

        // Reset while in REPEAT, button kept held afterwards
        n0 = n_inc;
        ifc.uphdnl_sw = 1'b0;
        ifc.btn_level = 1'b1;
        expect_inc(cyc + 1, 1'b0);
        clk1();
        clk1();
        repeat (3) pulse_tick(1'b0, 1'b0);
        ifc.tick = 1'b1;
        clk1();
        ifc.tick = 1'b0;
        chk("repeat_entry_inc", int'(ifc.inc), 1);
        chk("repeat_entry_state", int'(ifc.state), 2);
        reset = 1'b1;
        #1;
        chk("mid_rst_inc", int'(ifc.inc), 0);
        chk("mid_rst_state", int'(ifc.state), 0);
        chk("mid_rst_uphdnl", int'(ifc.uphdnl), 1);
        chk("mid_rst_at_limit", int'(ifc.at_limit), 0);
        repeat (2) clk1();
        reset = 1'b0;
        repeat (6) pulse_tick(1'b0, 1'b0);
        chk("post_rst_state", int'(ifc.state), 0);
        ifc.btn_level = 1'b0;
        sb_drain("post_rst_drain");
        chk("post_rst_count", n_inc - n0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/count_ctrl.md
COUNT_CTRL -- requirements
Module: count_ctrl

Interface
REQ-001 Parameter HOLD_TICKS, default 500: ticks the button must be held before auto-repeat starts (range 1..65535).
REQ-002 Parameter REPEAT_DIV, default 50: ticks between repeat steps (range 1..65535).
REQ-003 Parameters MAX_VAL, default 16'hFFFF, and MIN_VAL, default 16'h0000: saturation limits.
REQ-004 clk  in  1  system clock, all state on posedge clk.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 btn_level  in  1  debounced button level; 1 = pressed.
REQ-007 tick  in  1  single-cycle timebase strobe.
REQ-008 uphdnl_sw  in  1  direction switch; 1 = up, 0 = down.
REQ-009 auto_sw  in  1  free-run enable switch.
REQ-010 sat_sw  in  1  1 = saturate at limits; 0 = allow wrap-around.
REQ-011 q  in  16  current value of the controlled up/down counter.
REQ-012 inc  out  1  registered single-cycle step strobe to the counter.
REQ-013 uphdnl  out  1  registered direction to the counter, valid whenever inc = 1.
REQ-014 at_limit  out  1  registered; 1 when sat_sw = 1 and q equals the limit in the current direction.
REQ-015 state  out  2  FSM state code: IDLE = 0, PRESS = 1, REPEAT = 2, AUTO = 3.

Function
REQ-016 A press event is a rising edge of btn_level (btn_level = 1 and the registered previous sample = 0).
REQ-017 A step request is issued in the following cases:
  - IDLE: press event; next state is PRESS, and hold_cnt and rpt_cnt are cleared.
  - PRESS: each tick increments hold_cnt; on the tick where hold_cnt = HOLD_TICKS-1, issue a step, clear rpt_cnt and go to REPEAT.
  - REPEAT: each tick increments rpt_cnt; on the tick where rpt_cnt = REPEAT_DIV-1, issue a step and clear rpt_cnt.
  - AUTO: every tick.
REQ-018 btn_level = 0 in PRESS or REPEAT returns the FSM to IDLE next cycle; a tick in that same cycle issues no step.
REQ-019 auto_sw = 1 moves any state to AUTO next cycle; auto_sw has priority over button activity, and press events in AUTO are ignored.
REQ-020 auto_sw = 0 in AUTO moves the FSM to IDLE next cycle; a press event in that same cycle is not captured.
REQ-021 A step request in cycle n drives inc = 1 in cycle n+1, with uphdnl = uphdnl_sw sampled in cycle n; the latency is exactly 1 cycle.
REQ-022 uphdnl holds its last value while inc = 0.
REQ-023 Saturation: when sat_sw = 1, a request is suppressed if uphdnl_sw = 1 and q = MAX_VAL, or if uphdnl_sw = 0 and q = MIN_VAL.
  - A suppressed request produces no inc, but FSM counters advance normally.
REQ-024 When sat_sw = 0, requests are never suppressed; the counter wraps at 16'hFFFF/16'h0000.
REQ-025 inc is never high in two consecutive cycles; a request in the cycle in which inc = 1 is dropped, so back-to-back ticks yield alternating steps.
REQ-026 Exactly one inc pulse is produced per accepted request; no request is queued.
REQ-027 at_limit is updated every cycle from the registered comparison of q, uphdnl_sw and sat_sw (1-cycle latency).
REQ-028 hold_cnt and rpt_cnt are 16-bit and saturate; they do not wrap.

Reset
REQ-029 While reset = 1, asynchronously and without waiting for a clock edge:
  - state = IDLE;
  - inc = 0;
  - uphdnl = 1;
  - at_limit = 0;
  - hold_cnt, rpt_cnt and the btn_level previous sample = 0.
REQ-030 After reset deasserts, a button already held does not create a press event; it must be released and pressed again.
REQ-031 Reset asserted mid-PRESS or mid-REPEAT aborts the operation, and no inc pulse follows reset deassertion.

Verification
REQ-032 Reset with btn_level = 1 held, then release -> inc = 0 throughout, state = 0.
REQ-033 Single press, HOLD_TICKS = 4, release after 2 ticks, uphdnl_sw = 1 -> exactly one inc, 1 cycle after the press edge, uphdnl = 1, return to state 0.
REQ-034 Hold for 4+3·REPEAT_DIV ticks, HOLD_TICKS = 4, REPEAT_DIV = 2, releasing just after the last required tick -> 5 inc pulses total: press, entry to REPEAT, then one every 2 ticks.
REQ-035 auto_sw = 1, 10 ticks, press events interleaved -> 10 inc pulses, none from the presses, state = 3; auto_sw = 0 -> state = 0.
REQ-036 sat_sw = 1, uphdnl_sw = 0, q = 16'h0000, auto mode -> no inc, at_limit = 1; set uphdnl_sw = 1 -> inc resumes, at_limit = 0.
REQ-037 Reset pulse in REPEAT between ticks -> outputs at reset values immediately, no inc after release, state = 0.
